avr_bus_master: RTL



---
 rtl/avr_bus_pkg.sv | 19 +
 rtl/avr_addr_shifter.sv | 38 +++
 rtl/avr_bus_master.sv | 120 ++++++++++++
 3 files changed

// File: rtl/avr_bus_pkg.sv
// Shared types and constants for the AVR-side SRAM bus master.
// Holds FSM states, avr_ctrl command codes and the default address width.
package avr_bus_pkg;

  localparam int ADDR_W_DEF = 21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  localparam logic [2:0] CTRL_IDLE  = 3'b000;
  localparam logic [2:0] CTRL_READ  = 3'b001;
  localparam logic [2:0] CTRL_WRITE = 3'b010;

endpackage

// File: rtl/avr_addr_shifter.sv
// Parallel-load, MSB-first address serializer.
// o_done marks the final shift cycle so the master can leave SHIFT.
module avr_addr_shifter
  import avr_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_bit,
  output logic              o_done
);

  localparam int CW = $clog2(ADDR_W + 1);

  logic [ADDR_W-1:0] r_sreg;
  logic [CW-1:0]     r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[ADDR_W-2:0], 1'b0};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_bit  = r_sreg[ADDR_W-1];
  assign o_done = i_shift && (r_cnt == CW'(ADDR_W - 1));

endmodule

// File: rtl/avr_bus_master.sv
// AVR-side initiator: serial address shift, then an oe/we strobe.
// Repeated accesses to the last shifted address skip the shift phase.
module avr_bus_master
  import avr_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int ACC_CYCLES = 4
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              avr_si,
  output logic              avr_sreg_en,
  output logic              avr_ce,
  output logic              avr_oe,
  output logic              avr_we,
  output logic [2:0]        avr_ctrl,
  output logic [7:0]        avr_data_out,
  output logic              avr_data_oe,
  input  logic [7:0]        avr_data_in
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last_valid;
  logic [7:0]        r_wdata;
  logic              r_write;
  logic [3:0]        r_acc_cnt;
  logic [7:0]        r_rdata;

  logic w_accept;
  logic w_hit;
  logic w_sh_bit;
  logic w_sh_done;
  logic w_acc_last;
  logic w_busy;
  logic w_access;

  assign w_accept   = req_valid && req_ready;
  assign w_hit      = r_last_valid && (req_addr == r_last_addr);
  assign w_acc_last = (r_acc_cnt == 4'(ACC_CYCLES - 1));

  avr_addr_shifter #(
    .ADDR_W(ADDR_W)
  ) u_shifter (
    .i_clk  (avr_clk),
    .i_rst_n(avr_reset),
    .i_load (w_accept),
    .i_data (req_addr),
    .i_shift(r_state == ST_SHIFT),
    .o_bit  (w_sh_bit),
    .o_done (w_sh_done)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_hit ? ST_SETUP : ST_SHIFT;
      ST_SHIFT:  if (w_sh_done) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_acc_last) w_next = ST_HOLD;
      ST_HOLD:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge avr_clk) begin
    if (!avr_reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_acc_cnt    <= '0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_write <= req_write;
      end
      if (r_state == ST_SHIFT && w_sh_done) begin
        r_last_addr  <= r_addr;
        r_last_valid <= 1'b1;
      end
      r_acc_cnt <= w_access ? r_acc_cnt + 1'b1 : '0;
      // Read data is captured on the closing edge of the strobe window.
      if (w_access && w_acc_last && !r_write)
        r_rdata <= avr_data_in;
    end
  end

  assign w_access = (r_state == ST_ACCESS);
  assign w_busy   = (r_state == ST_SETUP) || w_access ||
                    (r_state == ST_HOLD);

  assign req_ready    = (r_state == ST_IDLE) && avr_reset;
  assign rsp_valid    = (r_state == ST_HOLD);
  assign rsp_rdata    = r_rdata;
  assign avr_sreg_en  = (r_state != ST_SHIFT);
  assign avr_si       = (r_state == ST_SHIFT) && w_sh_bit;
  assign avr_ce       = !w_busy;
  assign avr_oe       = !(w_access && !r_write);
  assign avr_we       = !(w_access && r_write);
  assign avr_ctrl     = !w_busy ? CTRL_IDLE :
                        (r_write ? CTRL_WRITE : CTRL_READ);
  assign avr_data_oe  = w_busy && r_write;
  assign avr_data_out = avr_data_oe ? r_wdata : 8'h00;

endmodule
